// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: fetch/decode/execute sequencing,
// memory handshake with optional wait timeout, and fault reporting.
module multicycle_control_unit #(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State,
    output logic [1:0]           Fault
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd2;
    localparam logic [3:0] A_OR   = 4'd3;
    localparam logic [3:0] A_XOR  = 4'd4;
    localparam logic [3:0] A_SLT  = 4'd5;
    localparam logic [3:0] A_SLL  = 4'd6;
    localparam logic [3:0] A_SRL  = 4'd7;
    localparam logic [3:0] A_SRA  = 4'd8;
    localparam logic [3:0] A_SLTU = 4'd9;

    // Counter only needs to reach MEM_TIMEOUT-1: the trap fires on that cycle.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    fault, nfault;
    logic [3:0]    alu, alu_f;
    logic [2:0]    imm_sel;
    logic          waiting, timeout;

    assign timeout    = (MEM_TIMEOUT > 0) && (cnt == LIMIT);
    assign ALUControl = ALUCTRL_W'(alu);
    assign State      = state;
    assign Fault      = fault;

    always_comb begin
        unique case (op)
            7'b0100011: imm_sel = 3'b001;
            7'b1100011: imm_sel = 3'b010;
            7'b1101111: imm_sel = 3'b100;
            default:    imm_sel = 3'b000;
        endcase
    end

    always_comb begin
        unique case (funct3)
            3'b000:  alu_f = (state == S_EXECR && funct7) ? A_SUB : A_ADD;
            3'b001:  alu_f = A_SLL;
            3'b010:  alu_f = A_SLT;
            3'b011:  alu_f = A_SLTU;
            3'b100:  alu_f = A_XOR;
            3'b101:  alu_f = funct7 ? A_SRA : A_SRL;
            3'b110:  alu_f = A_OR;
            default: alu_f = A_AND;
        endcase
    end

    always_comb begin
        nxt       = state;
        nfault    = fault;
        waiting   = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 3'b000;
        alu       = A_ADD;
        unique case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                waiting   = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timeout) begin
                    nxt    = S_TRAP;
                    nfault = 2'b10;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_sel;
                unique case (op)
                    7'b0000011,
                    7'b0100011: nxt = S_MEMADR;
                    7'b0110011: nxt = S_EXECR;
                    7'b0010011: nxt = S_EXECI;
                    7'b1100011: nxt = S_BRANCH;
                    7'b1101111: nxt = S_JAL;
                    default: begin
                        if (op == 7'b1100111 && funct3 == 3'b000) begin
                            nxt = S_JALR;
                        end else begin
                            nxt    = S_TRAP;
                            nfault = 2'b01;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_sel;
                if (funct3 != 3'b010) begin
                    nxt    = S_TRAP;
                    nfault = 2'b01;
                end else if (op == 7'b0100011) begin
                    nxt = S_MEMWRITE;
                end else begin
                    nxt = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                waiting = 1'b1;
                if (MemReady) begin
                    nxt = S_MEMWB;
                end else if (timeout) begin
                    nxt    = S_TRAP;
                    nfault = 2'b10;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                nxt       = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                waiting  = 1'b1;
                if (MemReady) begin
                    nxt = S_FETCH;
                end else if (timeout) begin
                    nxt    = S_TRAP;
                    nfault = 2'b10;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu     = alu_f;
                nxt     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu     = alu_f;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu     = A_SUB;
                if (funct3[2:1] == 2'b00) begin
                    PCWrite = Zero ^ funct3[0];
                    nxt     = S_FETCH;
                end else begin
                    nxt    = S_TRAP;
                    nfault = 2'b01;
                end
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                nxt     = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nxt     = S_JAL;
            end
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_IDLE;
        endcase
    end

    // Leaving any wait state clears the counter, so every entry starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            fault <= 2'b00;
            cnt   <= '0;
        end else begin
            state <= nxt;
            fault <= nfault;
            cnt   <= (waiting && !MemReady) ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus randomized
// instruction streams checked against a path-level reference model.
module tb_multicycle_control_unit;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, MemReq, MemWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] State;
    logic [1:0] Fault;

    multicycle_control_unit #(
        .ALUCTRL_W  (4),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl),
        .State     (State),
        .Fault     (Fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic       pcw, irw, rw, mreq, mw, adr;
        logic [1:0] res, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
    } ctl_t;

    // ALU code for funct3 0..7 before sub/sra overrides
    int alu_tab [8] = '{0, 6, 5, 9, 4, 7, 3, 2};

    int cur = 0;
    int mfault = 0;
    int wcnt = 0;
    int q[$];

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic ctl_t expect_ctl(input int s);
        ctl_t c;
        c = '0;
        case (s)
            1: begin
                c.mreq = 1; c.sb = 2; c.res = 2;
                c.irw = MemReady; c.pcw = MemReady;
            end
            2: begin c.sa = 1; c.sb = 1; c.imm = imm_of(op); end
            3: begin c.sa = 2; c.sb = 1; c.imm = imm_of(op); end
            4: begin c.mreq = 1; c.adr = 1; end
            5: begin c.res = 1; c.rw = 1; end
            6: begin c.mreq = 1; c.mw = 1; c.adr = 1; end
            7, 8: begin
                c.sa = 2;
                c.sb = (s == 8) ? 2'd1 : 2'd0;
                c.alu = 4'(alu_tab[funct3]);
                if (funct3 == 0 && s == 7 && funct7) c.alu = 1;
                if (funct3 == 5 && funct7) c.alu = 8;
            end
            9: c.rw = 1;
            10: begin
                c.sa = 2; c.alu = 1;
                if (funct3 < 2) c.pcw = Zero ^ funct3[0];
            end
            11: begin c.sa = 1; c.sb = 2; c.pcw = 1; end
            12: begin c.sa = 2; c.sb = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Remaining state path of one instruction, decided at DECODE
    task automatic build_path();
        q.delete();
        case (op)
            7'b0000011: q = (funct3 == 2) ? '{3, 4, 5, 1} : '{3, 13};
            7'b0100011: q = (funct3 == 2) ? '{3, 6, 1} : '{3, 13};
            7'b0110011: q = '{7, 9, 1};
            7'b0010011: q = '{8, 9, 1};
            7'b1100011: q = (funct3 < 2) ? '{10, 1} : '{10, 13};
            7'b1101111: q = '{11, 9, 1};
            7'b1100111: q = (funct3 == 0) ? '{12, 11, 9, 1} : '{13};
            default:    q = '{13};
        endcase
    endtask

    task automatic goto_next();
        cur = q.pop_front();
        if (cur == 13) mfault = 1;
    endtask

    task automatic advance();
        case (cur)
            0: cur = 1;
            1, 4, 6: begin
                if (MemReady) begin
                    wcnt = 0;
                    if (cur == 1) cur = 2;
                    else cur = q.pop_front();
                end else begin
                    wcnt++;
                    if (TO > 0 && wcnt == TO) begin
                        cur = 13;
                        mfault = 2;
                    end
                end
            end
            2: begin build_path(); goto_next(); end
            13: cur = 13;
            default: goto_next();
        endcase
    endtask

    always @(negedge clk) begin
        ctl_t e, g;
        g = {PCWrite, IRWrite, RegWrite, MemReq, MemWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
        if (!rst_n) begin
            chk("reset_ctl", g, 0);
            chk("reset_state", State, 0);
            chk("reset_fault", Fault, 0);
            cur = 0; mfault = 0; wcnt = 0;
            q.delete();
        end else begin
            e = expect_ctl(cur);
            chk("model_ctl", g, e);
            chk("model_state", State, cur);
            chk("model_fault", Fault, mfault);
            advance();
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input bit mr, input bit z);
        @(posedge clk);
        #1;
        MemReady = mr;
        Zero = z;
        settle();
    endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7);
        op = o; funct3 = f3; funct7 = f7;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0;
        MemReady = 0;
        Zero = 0;
        #1;
        chk("reset_async_state", State, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic rand_ins();
        logic [6:0] ops [8];
        int k;
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        k = $urandom_range(0, 7);
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) != 0) begin
            case (k)
                0, 1: f3 = 3'b010;
                4: f3 = 3'($urandom_range(0, 1));
                6: f3 = 3'b000;
                default: f3 = f3;
            endcase
        end
        set_ins(ops[k], f3, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        do_reset();
        // addi, memory ready on first fetch cycle
        set_ins(7'b0010011, 3'b000, 1'b0);
        MemReady = 1;
        settle();
        chk("addi_idle", State, 0);
        chk("addi_idle_memreq", MemReq, 0);
        step(1, 0);
        chk("addi_fetch", State, 1);
        chk("addi_irwrite", IRWrite, 1);
        chk("addi_pcwrite", PCWrite, 1);
        chk("addi_fetch_rw", RegWrite, 0);
        step(0, 0);
        chk("addi_decode", State, 2);
        chk("addi_decode_rw", RegWrite, 0);
        step(0, 0);
        chk("addi_execi", State, 8);
        chk("addi_alu", ALUControl, 0);
        chk("addi_execi_rw", RegWrite, 0);
        step(0, 0);
        chk("addi_aluwb", State, 9);
        chk("addi_aluwb_rw", RegWrite, 1);
        step(0, 0);
        chk("addi_refetch", State, 1);
        chk("fetch_wait_irwrite", IRWrite, 0);

        // lw with three stalled memory cycles
        set_ins(7'b0000011, 3'b010, 1'b0);
        step(1, 0);
        chk("lw_fetch", State, 1);
        step(0, 0);
        chk("lw_decode", State, 2);
        step(0, 0);
        chk("lw_memadr", State, 3);
        chk("lw_memadr_srca", ALUSrcA, 2);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 0);
            chk("lw_memread", State, 4);
            chk("lw_memreq", MemReq, 1);
            chk("lw_adrsrc", AdrSrc, 1);
        end
        step(0, 0);
        chk("lw_memwb", State, 5);
        chk("lw_result", ResultSrc, 1);
        chk("lw_regwrite", RegWrite, 1);
        step(0, 0);
        chk("lw_refetch", State, 1);

        // bne then beq, both with Zero=0
        set_ins(7'b1100011, 3'b001, 1'b0);
        step(1, 0);
        step(0, 0);
        chk("bne_imm", ImmSrc, 2);
        step(0, 0);
        chk("bne_branch", State, 10);
        chk("bne_pcwrite", PCWrite, 1);
        chk("bne_alu", ALUControl, 1);
        step(1, 0);
        chk("beq_fetch", State, 1);
        set_ins(7'b1100011, 3'b000, 1'b0);
        step(0, 0);
        step(0, 0);
        chk("beq_branch", State, 10);
        chk("beq_pcwrite", PCWrite, 0);

        // sub and sra through EXECR
        step(1, 0);
        set_ins(7'b0110011, 3'b000, 1'b1);
        step(0, 0);
        step(0, 0);
        chk("sub_execr", State, 7);
        chk("sub_alu", ALUControl, 1);
        step(0, 0);
        step(1, 0);
        set_ins(7'b0110011, 3'b101, 1'b1);
        step(0, 0);
        step(0, 0);
        chk("sra_alu", ALUControl, 8);
        step(0, 0);
        step(1, 0);

        // jalr
        set_ins(7'b1100111, 3'b000, 1'b0);
        step(0, 0);
        step(0, 0);
        chk("jalr_state", State, 12);
        step(0, 0);
        chk("jal_state", State, 11);
        chk("jal_pcwrite", PCWrite, 1);
        step(0, 0);
        chk("jalr_aluwb", State, 9);
        step(1, 0);

        // unsupported opcode traps and stays
        set_ins(7'b0110111, 3'b000, 1'b0);
        step(0, 0);
        chk("illegal_decode", State, 2);
        step(0, 0);
        chk("illegal_trap", State, 13);
        chk("illegal_fault", Fault, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("trap_strobes",
                {PCWrite, IRWrite, RegWrite, MemReq, MemWrite, AdrSrc}, 0);
            chk("trap_hold", {State, Fault}, {4'd13, 2'd1});
        end
        do_reset();
        settle();
        chk("trap_clear_state", State, 0);
        chk("trap_clear_fault", Fault, 0);

        // fetch timeout after TO waiting cycles
        for (int i = 0; i < TO; i++) begin
            step(0, 0);
            chk("to_fetch_wait", State, 1);
        end
        step(0, 0);
        chk("to_trap", State, 13);
        chk("to_fault", Fault, 2);
        do_reset();
        settle();
        for (int i = 0; i < TO; i++) begin
            step(i == TO - 1, 0);
            chk("to_edge_fetch", State, 1);
        end
        chk("to_edge_irwrite", IRWrite, 1);
        step(0, 0);
        chk("to_edge_decode", State, 2);

        // reset in the middle of a store
        do_reset();
        set_ins(7'b0100011, 3'b010, 1'b0);
        settle();
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("sw_memwrite", State, 6);
        chk("sw_memwrite_strobe", MemWrite, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_memreq", MemReq, 0);
        chk("async_memwrite", MemWrite, 0);
        chk("async_state", State, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        settle();
        chk("release_idle", State, 0);
        step(1, 0);
        chk("release_fetch", State, 1);

        // randomized instruction streams
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            rand_ins();
            for (int c = 0; c < 150; c++) begin
                @(posedge clk);
                #1;
                if (cur == 1) rand_ins();
                if (ep % 5 == 4) MemReady = ($urandom_range(0, 9) < 3);
                else MemReady = ($urandom_range(0, 9) < 7);
                Zero = 1'($urandom_range(0, 1));
            end
        end

        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
